// File: rtl/mixer_frame_ctrl_pkg.sv
// Shared types and defaults for the TX frame controller that drives the DDFS/MIXER pair.
package mixer_frame_ctrl_pkg;
    localparam int DEF_DW        = 18;
    localparam int DEF_FRAME_LEN = 2048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mixer_frame_fifo.sv
// Small synchronous FIFO buffering SRRC samples ahead of the mixer; head is read combinationally.
module mixer_frame_fifo #(
    parameter  int DEPTH = 8,
    parameter  int DW    = 18,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_wr;
    logic          w_rd;

    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign o_head  = r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/mixer_frame_ctrl.sv
// Sequences one TX frame: buffers SRRC samples, gates the shared DDFS/MIXER enable and tags Mout.
// The carrier only advances when a sample is issued, so starvation never breaks phase coherence.
module mixer_frame_ctrl
    import mixer_frame_ctrl_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int FILL_LVL   = 4,
    parameter int MIX_LAT    = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_s_valid,
    input  logic [DW-1:0] i_s_data,
    output logic          o_s_ready,
    output logic          o_phase_clr,
    output logic          o_mix_en,
    output logic [DW-1:0] o_mix_modin,
    input  logic [DW-1:0] i_mix_mout,
    output logic          o_m_valid,
    output logic [DW-1:0] o_m_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_underrun
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]      LAST     = CW'(FRAME_LEN);
    localparam logic [CW-1:0]      LAST_M1  = CW'(FRAME_LEN - 1);
    localparam logic [MIX_LAT:1]   VLD_TAIL = MIX_LAT'(1) << (MIX_LAT - 1);

    state_t          r_state;
    state_t          w_nxt;
    logic [CW-1:0]   r_acc_cnt;
    logic [CW-1:0]   r_iss_cnt;
    logic [CW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_fifo_cnt;
    logic [PW:0]     w_occ_nxt;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_mix_en;
    logic            w_s_ready;
    logic            w_acc_open;
    logic            w_fill_ok;
    logic            w_last_iss;
    logic            w_drain_ok;
    logic            w_start_ok;
    logic [DW-1:0]   w_head;
    logic [DW-1:0]   r_modin_hold;
    logic [DW-1:0]   r_m_data;
    logic [MIX_LAT:1] r_vld_pipe;
    logic            r_phase_clr;
    logic            r_underrun;

    mixer_frame_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_push  (w_push),
        .i_data  (i_s_data),
        .i_pop   (w_mix_en),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign w_acc_open = (r_acc_cnt != LAST);
    assign w_push     = i_s_valid && w_s_ready;
    assign w_acc_nxt  = r_acc_cnt + CW'(w_push);
    assign w_occ_nxt  = {1'b0, w_fifo_cnt} + (PW+1)'(w_push);
    // Count this cycle's push so RUN starts the cycle after the FILL_LVL-th accept.
    assign w_fill_ok  = (w_occ_nxt >= (PW+1)'(FILL_LVL)) || (w_acc_nxt == LAST);
    assign w_last_iss = w_mix_en && (r_iss_cnt == LAST_M1);
    // Nothing is issued in DRAIN, so the newest in-flight bit reaching the output is the last sample.
    assign w_drain_ok = (r_vld_pipe == VLD_TAIL);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)    w_nxt = ST_FILL;
            ST_FILL:  if (w_fill_ok)  w_nxt = ST_RUN;
            ST_RUN:   if (w_last_iss) w_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_ok) w_nxt = ST_DONE;
            ST_DONE:                  w_nxt = ST_IDLE;
            default:                  w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mix_en  = 1'b0;
        w_s_ready = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (r_state)
            ST_IDLE: o_busy = 1'b0;
            ST_FILL: w_s_ready = w_acc_open && !w_full;
            ST_RUN: begin
                w_mix_en  = !w_empty;
                w_s_ready = w_acc_open && (!w_full || !w_empty);
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_acc_cnt    <= '0;
            r_iss_cnt    <= '0;
            r_phase_clr  <= 1'b0;
            r_underrun   <= 1'b0;
            r_modin_hold <= '0;
            r_m_data     <= '0;
            r_vld_pipe   <= '0;
        end else begin
            r_phase_clr <= w_start_ok;
            if (w_start_ok) begin
                r_acc_cnt  <= '0;
                r_iss_cnt  <= '0;
                r_underrun <= 1'b0;
            end else begin
                if (w_push)   r_acc_cnt <= r_acc_cnt + 1'b1;
                if (w_mix_en) r_iss_cnt <= r_iss_cnt + 1'b1;
                if ((r_state == ST_RUN) && w_empty) r_underrun <= 1'b1;
            end
            if (w_mix_en)  r_modin_hold <= w_head;
            if (o_m_valid) r_m_data     <= i_mix_mout;
            r_vld_pipe[1] <= w_mix_en;
            for (int k = 2; k <= MIX_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
        end
    end

    assign o_s_ready   = w_s_ready;
    assign o_phase_clr = r_phase_clr;
    assign o_mix_en    = w_mix_en;
    assign o_mix_modin = w_mix_en ? w_head : r_modin_hold;
    assign o_m_valid   = r_vld_pipe[MIX_LAT];
    assign o_m_data    = r_m_data;
    assign o_underrun  = r_underrun;
endmodule

// File: tb/tb_mixer_frame_ctrl.sv
// Bench for mixer_frame_ctrl: full-length frames under several upstream rates, mid-frame reset,
// and a short-fill configuration, with a stand-in mixer and queue-based scoreboard.
module tb_mixer_frame_ctrl;
    localparam int DW  = 18;
    localparam int FL  = 2048;
    localparam int SFL = 4;

    typedef struct {
        int gap;
        bit dbl;
        bit exp_ur;
        int exp_lat;
        bit gapless;
    } frame_vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, phase_clr, mix_en, m_valid, busy, done, underrun;
    logic [DW-1:0] mix_modin, mix_mout, m_data;

    logic          b_start = 1'b0, b_s_valid = 1'b0;
    logic [DW-1:0] b_s_data = '0;
    logic          b_s_ready, b_phase_clr, b_mix_en, b_m_valid, b_busy, b_done, b_underrun;
    logic [DW-1:0] b_mix_modin, b_mix_mout, b_m_data;

    mixer_frame_ctrl #(.DW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(8), .FILL_LVL(4), .MIX_LAT(1)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_s_valid(s_valid), .i_s_data(s_data),
        .o_s_ready(s_ready), .o_phase_clr(phase_clr), .o_mix_en(mix_en), .o_mix_modin(mix_modin),
        .i_mix_mout(mix_mout), .o_m_valid(m_valid), .o_m_data(m_data), .o_busy(busy),
        .o_done(done), .o_underrun(underrun)
    );

    mixer_frame_ctrl #(.DW(DW), .FRAME_LEN(SFL), .FIFO_DEPTH(8), .FILL_LVL(8), .MIX_LAT(1)) dut_s (
        .i_clk(clk), .i_reset(rst_n), .i_start(b_start), .i_s_valid(b_s_valid), .i_s_data(b_s_data),
        .o_s_ready(b_s_ready), .o_phase_clr(b_phase_clr), .o_mix_en(b_mix_en),
        .o_mix_modin(b_mix_modin), .i_mix_mout(b_mix_mout), .o_m_valid(b_m_valid),
        .o_m_data(b_m_data), .o_busy(b_busy), .o_done(b_done), .o_underrun(b_underrun)
    );

    function automatic logic [DW-1:0] mix_f(input logic [DW-1:0] x);
        return ~x + 18'h01234;
    endfunction

    // Stand-in MIXER: one register stage, advancing only on en.
    always @(posedge clk) if (mix_en)   mix_mout   <= mix_f(mix_modin);
    always @(posedge clk) if (b_mix_en) b_mix_mout <= mix_f(b_mix_modin);

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    logic [DW-1:0] sb_iss[$];
    logic [DW-1:0] sb_out[$];
    int            mv_cnt = 0, done_cnt = 0, pc_cnt = 0, en_cnt = 0;
    int            cyc = 0, first_mv = 0, last_mv = 0;
    bit            pend = 0;
    logic [DW-1:0] pend_exp = '0;
    logic [DW-1:0] last_modin = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (pend) begin
                chk("m_data", m_data, pend_exp);
                pend = 0;
            end
            if (m_valid) begin
                chk("m_valid_expected", sb_out.size() != 0, 1);
                if (sb_out.size() != 0) begin
                    pend_exp = sb_out.pop_front();
                    pend = 1;
                end
                if (mv_cnt == 0) first_mv = cyc;
                last_mv = cyc;
                mv_cnt++;
            end
            if (mix_en) begin
                chk("issue_expected", sb_iss.size() != 0, 1);
                if (sb_iss.size() != 0) chk("mix_modin_order", mix_modin, sb_iss.pop_front());
                last_modin = mix_modin;
                en_cnt++;
            end else begin
                chk("mix_modin_hold", mix_modin, last_modin);
            end
            if (done)      done_cnt++;
            if (phase_clr) pc_cnt++;
        end
    end

    task automatic run_frame(input frame_vec_t v);
        int acc, since, acc_cyc, run_cyc, n;
        bit fin;
        acc = 0; since = v.gap; acc_cyc = -1; run_cyc = -1; n = 0; fin = 0;
        mv_cnt = 0; done_cnt = 0; pc_cnt = 0; en_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("phase_clr_after_start", phase_clr, 1);
        chk("busy_after_start", busy, 1);
        while (!fin && n < 20000) begin
            start   = v.dbl && (n == 1500);
            s_valid = (since >= v.gap) && (acc < FL);
            s_data  = DW'(acc);
            if (s_valid && s_ready) begin
                if (acc == 0) acc_cyc = n;
                sb_iss.push_back(s_data);
                sb_out.push_back(mix_f(s_data));
                acc++;
                since = 0;
            end
            if (mix_en && run_cyc < 0) run_cyc = n;
            if (done) fin = 1'b1;
            since++;
            n++;
            @(negedge clk);
        end
        start = 1'b0; s_valid = 1'b0;
        chk("frame_done_seen", fin, 1);
        repeat (5) @(negedge clk);
        chk("accepted", acc, FL);
        chk("run_latency", run_cyc - acc_cyc, v.exp_lat);
        chk("m_valid_count", mv_cnt, FL);
        chk("mix_en_count", en_cnt, FL);
        chk("done_count", done_cnt, 1);
        chk("phase_clr_count", pc_cnt, 1);
        chk("underrun", underrun, v.exp_ur);
        chk("sb_drained", sb_out.size(), 0);
        chk("busy_idle", busy, 0);
        chk("s_ready_idle", s_ready, 0);
        if (v.gapless) chk("m_valid_span", last_mv - first_mv + 1, FL);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_phase_clr"}, phase_clr, 0);
        chk({tag, "_mix_en"}, mix_en, 0);
        chk({tag, "_mix_modin"}, mix_modin, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic abort_frame();
        int acc, n;
        acc = 0; n = 0; mv_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (mv_cnt < 1000 && n < 5000) begin
            s_valid = (acc < FL);
            s_data  = DW'(acc);
            if (s_valid && s_ready) begin
                sb_iss.push_back(s_data);
                sb_out.push_back(mix_f(s_data));
                acc++;
            end
            n++;
            @(negedge clk);
        end
        chk("abort_reached_1000", mv_cnt >= 1000, 1);
        chk("abort_busy_before", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0; s_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_iss.delete(); sb_out.delete();
        pend = 0; last_modin = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic short_fill();
        int bacc, bk, ben, bmv, bdone, bpc;
        bit bpend;
        logic [DW-1:0] bexp;
        logic [DW-1:0] bq[$];
        bacc = 0; bk = -1; ben = -1; bmv = 0; bdone = 0; bpc = 0; bpend = 0; bexp = '0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bpend) begin
                chk("short_m_data", b_m_data, bexp);
                bpend = 0;
            end
            if (b_m_valid) begin
                bmv++;
                if (bq.size() != 0) begin
                    bexp = bq.pop_front();
                    bpend = 1;
                end
            end
            if (b_done)      bdone++;
            if (b_phase_clr) bpc++;
            if (b_mix_en && ben < 0) ben = n;
            b_s_valid = 1'b1;
            b_s_data  = DW'(100 + bacc);
            if (b_s_ready) begin
                if (bacc == 0) bk = n;
                bq.push_back(mix_f(b_s_data));
                bacc++;
            end
            @(negedge clk);
        end
        b_s_valid = 1'b0;
        chk("short_accepts", bacc, SFL);
        chk("short_run_latency", ben - bk, 4);
        chk("short_m_valid", bmv, SFL);
        chk("short_done", bdone, 1);
        chk("short_phase_clr", bpc, 1);
        chk("short_underrun", b_underrun, 0);
        chk("short_busy_end", b_busy, 0);
        chk("short_s_ready_end", b_s_ready, 0);
    endtask

    frame_vec_t vecs[4];

    initial begin
        vecs[0] = '{gap: 1, dbl: 1'b0, exp_ur: 1'b0, exp_lat: 4,  gapless: 1'b1};
        vecs[1] = '{gap: 3, dbl: 1'b0, exp_ur: 1'b1, exp_lat: 10, gapless: 1'b0};
        vecs[2] = '{gap: 1, dbl: 1'b1, exp_ur: 1'b0, exp_lat: 4,  gapless: 1'b1};
        vecs[3] = '{gap: 2, dbl: 1'b0, exp_ur: 1'b1, exp_lat: 7,  gapless: 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_short_busy", b_busy, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        abort_frame();
        repeat (2) @(negedge clk);
        check_reset_outputs("after_release");
        run_frame(vecs[0]);

        short_fill();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
